// File: rtl/pb_multi_conditioner.sv
// ----------------------------------------------------------------------------
// pb_multi_conditioner
//
// Conditions N independent push-button channels for use by FSM/counter logic
// running on the system clock. Each channel has:
//   - a 2-flop synchroniser on the raw input,
//   - a sample-count debouncer producing a clean level,
//   - a small FSM (IDLE / PRESSED / LONG) producing one-cycle press and
//     release pulses, a long-press level, and optional auto-repeat presses.
//
// Ports
//   clk         in   1  system clock, all logic on the rising edge
//   rst_n       in   1  asynchronous, active-low reset
//   pb_in       in   N  raw button inputs, active high, asynchronous to clk
//   rpt_en      in   N  per-channel auto-repeat enable, sampled every cycle
//   pb_deb      out  N  debounced level
//   pb_press    out  N  1-cycle pulse on press and on each auto-repeat
//   pb_release  out  N  1-cycle pulse on release
//   pb_long     out  N  level, high while long-press is active
// ----------------------------------------------------------------------------
module pb_multi_conditioner #(
    parameter int N        = 4,
    parameter int DEB_LEN  = 4,
    parameter int HOLD_CYC = 100,
    parameter int RPT_CYC  = 25
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] pb_in,
    input  logic [N-1:0] rpt_en,
    output logic [N-1:0] pb_deb,
    output logic [N-1:0] pb_press,
    output logic [N-1:0] pb_release,
    output logic [N-1:0] pb_long
);

    localparam int DW = $clog2(DEB_LEN + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int RW = $clog2(RPT_CYC + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_LEN - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYC);
    localparam logic [RW-1:0] RPT_LAST  = RW'(RPT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    logic [N-1:0]         sync1_q, sync1_d;
    logic [N-1:0]         sync2_q, sync2_d;
    logic [N-1:0]         deb_q, deb_d;
    logic [N-1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [N-1:0][HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [N-1:0][RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [N-1:0]         press_q, press_d;
    logic [N-1:0]         release_q, release_d;
    logic [N-1:0]         long_q, long_d;
    state_t               state_q [N];
    state_t               state_d [N];

    // Next-state logic for every channel. The FSM reacts to the debouncer's
    // next value (deb_d) so that press/release pulses are registered on the
    // very same edge that pb_deb changes. A release always takes priority
    // over a hold or repeat terminal count landing on the same edge.
    always_comb begin
        sync1_d    = pb_in;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rpt_cnt_d  = rpt_cnt_q;
        press_d    = '0;
        release_d  = '0;
        long_d     = '0;
        state_d    = state_q;

        for (int i = 0; i < N; i++) begin
            // Debounce: count consecutive disagreeing samples; any agreeing
            // sample restarts the count, so short bounces never get through.
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_d[i]     = ~deb_q[i];
                    deb_cnt_d[i] = '0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end else begin
                deb_cnt_d[i] = '0;
            end

            case (state_q[i])
                IDLE: begin
                    if (deb_d[i] && !deb_q[i]) begin
                        state_d[i]    = PRESSED;
                        press_d[i]    = 1'b1;
                        hold_cnt_d[i] = '0;
                    end
                end
                PRESSED: begin
                    if (!deb_d[i] && deb_q[i]) begin
                        state_d[i]   = IDLE;
                        release_d[i] = 1'b1;
                    end else if (hold_cnt_q[i] == HOLD_LAST) begin
                        // hold_cnt parks at HOLD_CYC for the rest of the press
                        state_d[i]    = LONG;
                        hold_cnt_d[i] = HOLD_SAT;
                        rpt_cnt_d[i]  = '0;
                        press_d[i]    = rpt_en[i];
                    end else begin
                        hold_cnt_d[i] = hold_cnt_q[i] + HW'(1);
                    end
                end
                LONG: begin
                    if (!deb_d[i] && deb_q[i]) begin
                        state_d[i]   = IDLE;
                        release_d[i] = 1'b1;
                    end else if (rpt_cnt_q[i] == RPT_LAST) begin
                        // The repeat counter free-runs so toggling rpt_en
                        // never shifts the phase of later repeats.
                        rpt_cnt_d[i] = '0;
                        press_d[i]   = rpt_en[i];
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + RW'(1);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                end
            endcase

            long_d[i] = (state_d[i] == LONG);
        end
    end

    // State registers; everything clears immediately when rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            rpt_cnt_q  <= '0;
            press_q    <= '0;
            release_q  <= '0;
            long_q     <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rpt_cnt_q  <= rpt_cnt_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            state_q    <= state_d;
        end
    end

    assign pb_deb     = deb_q;
    assign pb_press   = press_q;
    assign pb_release = release_q;
    assign pb_long    = long_q;

endmodule

// File: tb/tb_pb_multi_conditioner.sv
// ----------------------------------------------------------------------------
// tb_pb_multi_conditioner
//
// Random press episodes (with bounce, long holds, auto-repeat) are generated
// per channel as input waveforms. For every episode the expected output
// events are computed from the button timing rules and queued per channel.
// A monitor watches the DUT outputs every cycle and matches each observed
// event against the queue. A directed phase covers reset during a long press.
// ----------------------------------------------------------------------------
module tb_pb_multi_conditioner;

    localparam int N        = 4;
    localparam int DEB_LEN  = 4;
    localparam int HOLD_CYC = 100;
    localparam int RPT_CYC  = 25;
    localparam int LAT      = 2 + DEB_LEN;
    localparam int W        = 3000;

    localparam int K_DEB_RISE  = 0;
    localparam int K_DEB_FALL  = 1;
    localparam int K_PRESS     = 2;
    localparam int K_RELEASE   = 3;
    localparam int K_LONG_RISE = 4;
    localparam int K_LONG_FALL = 5;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic [N-1:0] pb_in  = '0;
    logic [N-1:0] rpt_en = '0;
    logic [N-1:0] pb_deb;
    logic [N-1:0] pb_press;
    logic [N-1:0] pb_release;
    logic [N-1:0] pb_long;

    ev_t          exp_q [N][$];
    logic [N-1:0] wave_pb  [W];
    logic [N-1:0] wave_rpt [W];
    logic [N-1:0] prev_deb;
    logic [N-1:0] prev_long;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    pb_multi_conditioner #(
        .N(N), .DEB_LEN(DEB_LEN), .HOLD_CYC(HOLD_CYC), .RPT_CYC(RPT_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pb_in(pb_in),
        .rpt_en(rpt_en),
        .pb_deb(pb_deb),
        .pb_press(pb_press),
        .pb_release(pb_release),
        .pb_long(pb_long)
    );

    // Free-running clock and cycle counter used to timestamp events
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic string kname(input int k);
        case (k)
            K_DEB_RISE:  return "deb_rise";
            K_DEB_FALL:  return "deb_fall";
            K_PRESS:     return "press";
            K_RELEASE:   return "release";
            K_LONG_RISE: return "long_rise";
            K_LONG_FALL: return "long_fall";
            default:     return "unknown";
        endcase
    endfunction

    task automatic pushEv(input int ch, input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        exp_q[ch].push_back(e);
    endtask

    // Match one observed output event against the head of the channel queue
    task automatic checkOutput(input int ch, input int kind);
        ev_t e;
        checks++;
        if (exp_q[ch].size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event ch%0d: got %s at cycle %0d, required no event",
                     ch, kname(kind), cyc);
        end else begin
            e = exp_q[ch].pop_front();
            if (e.cyc != cyc || e.kind != kind) begin
                errors++;
                $display("[TB] FAIL event ch%0d: got %s at cycle %0d, required %s at cycle %0d",
                         ch, kname(kind), cyc, kname(e.kind), e.cyc);
            end
        end
    endtask

    task automatic compareVec(input string name, input logic [N-1:0] act,
                              input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic checkZero(input string label);
        compareVec({label, "_deb"},     pb_deb,     '0);
        compareVec({label, "_press"},   pb_press,   '0);
        compareVec({label, "_release"}, pb_release, '0);
        compareVec({label, "_long"},    pb_long,    '0);
    endtask

    task automatic checkQueuesEmpty(input string label);
        for (int ch = 0; ch < N; ch++) begin
            checks++;
            if (exp_q[ch].size() != 0) begin
                errors++;
                $display("[TB] FAIL %s_missing ch%0d: got %0d events outstanding (next %s at cycle %0d), required 0",
                         label, ch, exp_q[ch].size(), kname(exp_q[ch][0].kind), exp_q[ch][0].cyc);
            end
            exp_q[ch].delete();
        end
    endtask

    // Expected events of one episode: deb rises at t0 and falls at t0+h.
    // Long press and repeats only happen strictly before the release.
    task automatic expectEpisode(input int ch, input int t0, input int h, input bit r);
        pushEv(ch, t0, K_DEB_RISE);
        pushEv(ch, t0, K_PRESS);
        if (h > HOLD_CYC) begin
            if (r) pushEv(ch, t0 + HOLD_CYC, K_PRESS);
            pushEv(ch, t0 + HOLD_CYC, K_LONG_RISE);
            for (int k = t0 + HOLD_CYC + RPT_CYC; k < t0 + h; k += RPT_CYC) begin
                if (r) pushEv(ch, k, K_PRESS);
            end
        end
        pushEv(ch, t0 + h, K_DEB_FALL);
        pushEv(ch, t0 + h, K_RELEASE);
        if (h > HOLD_CYC) pushEv(ch, t0 + h, K_LONG_FALL);
    endtask

    // Monitor: turns output edges and pulses into events, in a fixed order
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_deb  <= '0;
            prev_long <= '0;
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                if (pb_deb[ch] && !prev_deb[ch])   checkOutput(ch, K_DEB_RISE);
                if (!pb_deb[ch] && prev_deb[ch])   checkOutput(ch, K_DEB_FALL);
                if (pb_press[ch])                  checkOutput(ch, K_PRESS);
                if (pb_release[ch])                checkOutput(ch, K_RELEASE);
                if (pb_long[ch] && !prev_long[ch]) checkOutput(ch, K_LONG_RISE);
                if (!pb_long[ch] && prev_long[ch]) checkOutput(ch, K_LONG_FALL);
                if (pb_press[ch] && pb_release[ch]) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL press_and_release ch%0d at cycle %0d: got both high, required at most one",
                             ch, cyc);
                end
            end
            prev_deb  <= pb_deb;
            prev_long <= pb_long;
        end
    end

    // Build random waveforms for every channel, queue the expected events,
    // then play the waveforms one value per clock.
    task automatic applyStimulus();
        int base;
        int idx, start, e, f, h, nb, w, p;
        bit r;
        for (int j = 0; j < W; j++) begin
            wave_pb[j]  = '0;
            wave_rpt[j] = '0;
        end
        @(posedge clk);
        #1;
        base = cyc;
        for (int ch = 0; ch < N; ch++) begin
            idx = 5 + $urandom_range(0, 20);
            while (idx < W) begin
                case ($urandom_range(0, 7))
                    0:       h = HOLD_CYC;
                    1:       h = HOLD_CYC + RPT_CYC;
                    2:       h = HOLD_CYC + 1;
                    3:       h = 190;
                    4:       h = 50;
                    5:       h = HOLD_CYC + 2 * RPT_CYC + $urandom_range(0, 1);
                    default: h = $urandom_range(12, 260);
                endcase
                if (idx + 25 + h + 45 > W) break;
                start = idx;
                r     = 1'($urandom_range(0, 1));
                nb    = $urandom_range(0, 3);
                for (int g = 0; g < nb; g++) begin
                    idx += $urandom_range(1, DEB_LEN - 1);
                    w = $urandom_range(1, DEB_LEN - 1);
                    for (int j = idx; j < idx + w; j++) wave_pb[j][ch] = 1'b1;
                    idx += w;
                end
                if (nb > 0) idx += $urandom_range(1, 3);
                e = idx;
                f = e + h;
                for (int j = e; j < f; j++) wave_pb[j][ch] = 1'b1;
                if (h >= 30 && $urandom_range(0, 1) == 1) begin
                    p = f - 15;
                    while (1) begin
                        p += $urandom_range(1, 3);
                        w = $urandom_range(1, DEB_LEN - 1);
                        if (p + w >= f) break;
                        for (int j = p; j < p + w; j++) wave_pb[j][ch] = 1'b0;
                        p += w;
                    end
                end
                for (int j = start; j < f + 12; j++) wave_rpt[j][ch] = r;
                expectEpisode(ch, base + e + LAT, h, r);
                idx = f + 12 + $urandom_range(0, 30);
            end
        end
        for (int i = 0; i < W; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            pb_in  = wave_pb[i];
            rpt_en = wave_rpt[i];
        end
        pb_in  = '0;
        rpt_en = '0;
    endtask

    // Reset while channel 0 is in a long press: outputs clear without a clock,
    // and after reset the still-held button is seen as a fresh press.
    task automatic resetMidPress();
        int c, t0, r, f;
        @(posedge clk);
        #1;
        c      = cyc;
        rpt_en = '1;
        pb_in  = N'(1);
        t0     = c + LAT;
        pushEv(0, t0, K_DEB_RISE);
        pushEv(0, t0, K_PRESS);
        pushEv(0, t0 + HOLD_CYC, K_PRESS);
        pushEv(0, t0 + HOLD_CYC, K_LONG_RISE);
        while (cyc < t0 + 120) begin
            @(posedge clk);
            #1;
        end
        compareVec("long_before_reset", pb_long, N'(1));
        #1 rst_n = 1'b0;
        #1;
        checkZero("async_reset");
        checkQueuesEmpty("pre_reset");
        repeat (3) begin
            @(posedge clk);
            #1;
            checkZero("held_reset");
        end
        rst_n = 1'b1;
        r  = cyc;
        t0 = r + LAT;
        f  = r + 130;
        pushEv(0, t0, K_DEB_RISE);
        pushEv(0, t0, K_PRESS);
        pushEv(0, t0 + HOLD_CYC, K_PRESS);
        pushEv(0, t0 + HOLD_CYC, K_LONG_RISE);
        for (int k = t0 + HOLD_CYC + RPT_CYC; k < f + LAT; k += RPT_CYC) pushEv(0, k, K_PRESS);
        pushEv(0, f + LAT, K_DEB_FALL);
        pushEv(0, f + LAT, K_RELEASE);
        pushEv(0, f + LAT, K_LONG_FALL);
        while (cyc < f) begin
            @(posedge clk);
            #1;
        end
        pb_in = '0;
        while (cyc < f + LAT + 20) begin
            @(posedge clk);
            #1;
        end
        checkQueuesEmpty("reset_phase");
    endtask

    initial begin
        $display("[TB] start");
        #1 rst_n = 1'b0;
        #1;
        checkZero("reset_state");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus();
        repeat (60) @(posedge clk);
        #1;
        checkQueuesEmpty("random");
        resetMidPress();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
